// File: rtl/hienthiled_scan_pkg.sv
// Shared constants and helpers for the multiplexed countdown display: digit map,
// colour codes, BCD saturation and one double-dabble step.
package hienthiled_scan_pkg;

    localparam logic [2:0] COLOR_RED    = 3'd1;
    localparam logic [2:0] COLOR_YELLOW = 3'd2;
    localparam logic [2:0] COLOR_GREEN  = 3'd4;

    localparam int         BCD_SAT   = 99;
    localparam logic [6:0] BCD_SAT_7 = 7'd99;

    // Active-high "all segments off"; polarity is applied at the output.
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic int units_idx(input int c);
        return 2 * c;
    endfunction

    function automatic int tens_idx(input int c);
        return 2 * c + 1;
    endfunction

    function automatic int color_idx(input int c, input int num_ch);
        return 2 * num_ch + c;
    endfunction

    // Layout {tens[3:0], units[3:0], bin[6:0]}: add-3 on BCD nibbles >= 5, then shift left.
    function automatic logic [14:0] dd_step(input logic [14:0] v);
        logic [14:0] a;
        a = v;
        if (a[14:11] >= 4'd5) a[14:11] = a[14:11] + 4'd3;
        if (a[10:7] >= 4'd5) a[10:7] = a[10:7] + 4'd3;
        return {a[13:0], 1'b0};
    endfunction

endpackage

// File: rtl/hienthiled_scan_giaimabaythanh.sv
// Hex nibble to seven-segment glyph, active-high, bit order {g,f,e,d,c,b,a}.
module giaimabaythanh (
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'h00;
        case (i_bcd)
            4'h0: o_seg = 7'h3F;
            4'h1: o_seg = 7'h06;
            4'h2: o_seg = 7'h5B;
            4'h3: o_seg = 7'h4F;
            4'h4: o_seg = 7'h66;
            4'h5: o_seg = 7'h6D;
            4'h6: o_seg = 7'h7D;
            4'h7: o_seg = 7'h07;
            4'h8: o_seg = 7'h7F;
            4'h9: o_seg = 7'h6F;
            4'hA: o_seg = 7'h77;
            4'hB: o_seg = 7'h7C;
            4'hC: o_seg = 7'h39;
            4'hD: o_seg = 7'h5E;
            4'hE: o_seg = 7'h79;
            4'hF: o_seg = 7'h71;
            default: o_seg = 7'h00;
        endcase
    end

endmodule

// File: rtl/hienthiled_scan.sv
// Time-multiplexed display driver: captures NUM_CH countdowns and colours, converts them
// to BCD with a shared-timing double-dabble engine and scans 3*NUM_CH digits on one bus.
module hienthiled_scan
    import hienthiled_scan_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int CNT_W          = 8,
    parameter int SCAN_DIV       = 1000,
    parameter int BLINK_FRAMES   = 64,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH*CNT_W-1:0]   count_in,
    input  logic [NUM_CH*3-1:0]       color_in,
    input  logic                      load,
    input  logic [NUM_CH-1:0]         blink_en,
    output logic [6:0]                seg,
    output logic [3*NUM_CH-1:0]       dig_sel,
    output logic                      busy,
    output logic                      frame_tick
);

    localparam int NDIG  = 3 * NUM_CH;
    localparam int IDX_W = $clog2(NDIG);
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int FC_W  = $clog2(BLINK_FRAMES + 1);
    localparam logic [6:0] SEG_RST = SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    logic [1:0]       r_state;
    logic [2:0]       r_shift_cnt;
    logic             r_pending;
    logic [14:0]      r_dd       [NUM_CH];
    logic [2:0]       r_col_snap [NUM_CH];
    logic [3:0]       r_units    [NUM_CH];
    logic [3:0]       r_tens     [NUM_CH];
    logic [2:0]       r_col      [NUM_CH];

    logic [PRE_W-1:0] r_presc;
    logic [IDX_W-1:0] r_idx;
    logic [FC_W-1:0]  r_fcnt;
    logic             r_phase;
    logic [6:0]       r_seg;
    logic [NDIG-1:0]  r_dig_sel;
    logic             r_frame_tick;

    logic [6:0]       w_sat     [NUM_CH];
    logic [3:0]       w_units_n [NUM_CH];
    logic [3:0]       w_tens_n  [NUM_CH];
    logic [2:0]       w_col_n   [NUM_CH];
    logic             w_commit;
    logic             w_pre_tc;
    logic             w_idx_last;
    logic             w_wrap;
    logic             w_fcnt_tc;
    logic             w_phase_n;
    logic [IDX_W-1:0] w_idx_n;
    logic [NDIG-1:0]  w_dig_n;
    logic [3:0]       w_nib;
    logic             w_zero_tens;
    logic             w_ch_blink;
    logic             w_blank;
    logic [6:0]       w_seg_dec;
    logic [6:0]       w_seg_lit;
    logic [6:0]       w_seg_n;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (count_in[c*CNT_W +: CNT_W] > CNT_W'(BCD_SAT)) w_sat[c] = BCD_SAT_7;
            else w_sat[c] = count_in[c*CNT_W +: 7];
        end
    end

    // Capture, 7 shift cycles, then one commit cycle; loads while busy collapse into r_pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_shift_cnt <= 3'd0;
            r_pending   <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_dd[c]       <= '0;
                r_col_snap[c] <= '0;
                r_units[c]    <= '0;
                r_tens[c]     <= '0;
                r_col[c]      <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (load || r_pending) begin
                        for (int c = 0; c < NUM_CH; c++) begin
                            r_dd[c]       <= {8'd0, w_sat[c]};
                            r_col_snap[c] <= color_in[c*3 +: 3];
                        end
                        r_shift_cnt <= 3'd0;
                        r_pending   <= 1'b0;
                        r_state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    for (int c = 0; c < NUM_CH; c++) r_dd[c] <= dd_step(r_dd[c]);
                    r_shift_cnt <= r_shift_cnt + 3'd1;
                    if (r_shift_cnt == 3'd6) r_state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        r_units[c] <= r_dd[c][10:7];
                        r_tens[c]  <= r_dd[c][14:11];
                        r_col[c]   <= r_col_snap[c];
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
            if (r_state != ST_IDLE && load) r_pending <= 1'b1;
        end
    end

    assign w_commit = (r_state == ST_COMMIT);
    assign busy     = (r_state != ST_IDLE);

    // Bypass the commit so seg shows new digits on the same edge the registers take them.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_units_n[c] = w_commit ? r_dd[c][10:7]  : r_units[c];
            w_tens_n[c]  = w_commit ? r_dd[c][14:11] : r_tens[c];
            w_col_n[c]   = w_commit ? r_col_snap[c]  : r_col[c];
        end
    end

    assign w_pre_tc   = (r_presc == PRE_W'(SCAN_DIV - 1));
    assign w_idx_last = (r_idx == IDX_W'(NDIG - 1));
    assign w_wrap     = w_pre_tc && w_idx_last;
    assign w_fcnt_tc  = (r_fcnt == FC_W'(BLINK_FRAMES - 1));
    assign w_phase_n  = (w_wrap && w_fcnt_tc) ? ~r_phase : r_phase;
    assign w_idx_n    = w_pre_tc ? (w_idx_last ? '0 : r_idx + 1'b1) : r_idx;
    assign w_dig_n    = NDIG'(1) << w_idx_n;

    always_comb begin
        w_nib       = 4'd0;
        w_zero_tens = 1'b0;
        w_ch_blink  = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_idx_n == IDX_W'(units_idx(c))) begin
                w_nib      = w_units_n[c];
                w_ch_blink = blink_en[c];
            end
            if (w_idx_n == IDX_W'(tens_idx(c))) begin
                w_nib       = w_tens_n[c];
                w_zero_tens = (w_tens_n[c] == 4'd0);
                w_ch_blink  = blink_en[c];
            end
            if (w_idx_n == IDX_W'(color_idx(c, NUM_CH))) begin
                w_nib      = {1'b0, w_col_n[c]};
                w_ch_blink = blink_en[c];
            end
        end
    end

    giaimabaythanh u_giaimabaythanh (
        .i_bcd (w_nib),
        .o_seg (w_seg_dec)
    );

    assign w_blank   = w_zero_tens | (w_phase_n & w_ch_blink);
    assign w_seg_lit = w_blank ? SEG_BLANK : w_seg_dec;
    assign w_seg_n   = SEG_ACTIVE_LOW ? ~w_seg_lit : w_seg_lit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc      <= '0;
            r_idx        <= '0;
            r_fcnt       <= '0;
            r_phase      <= 1'b0;
            r_seg        <= SEG_RST;
            r_dig_sel    <= NDIG'(1);
            r_frame_tick <= 1'b0;
        end else begin
            r_presc <= w_pre_tc ? '0 : r_presc + 1'b1;
            r_idx   <= w_idx_n;
            if (w_wrap) r_fcnt <= w_fcnt_tc ? '0 : r_fcnt + 1'b1;
            r_phase      <= w_phase_n;
            r_seg        <= w_seg_n;
            r_dig_sel    <= w_dig_n;
            r_frame_tick <= w_wrap;
        end
    end

    assign seg        = r_seg;
    assign dig_sel    = r_dig_sel;
    assign frame_tick = r_frame_tick;

endmodule

// File: doc/hienthiled_scan.md
# hienthiled_scan

Parametrised, time-multiplexed seven-segment display driver for the traffic light controller. Accepts NUM_CH binary countdown values and colour codes, converts each count to two BCD digits with an iterative double-dabble engine, and scans all 3*NUM_CH digits over a single shared segment bus. Adds saturation, leading-zero blanking and per-channel blinking. Sits between the light FSM/counters and the board's multiplexed LED digits.

## Interface
- NUM_CH, 2, number of road channels (≥1)
- CNT_W, 8, width of each binary count (≥7)
- SCAN_DIV, 1000, clock cycles each digit stays lit (≥2)
- BLINK_FRAMES, 64, scan frames per blink half-period (≥1)
- SEG_ACTIVE_LOW, 1, 1: segment lit when bit = 0
- clk  in  1  single system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- count_in  in  NUM_CH*CNT_W  binary counts, channel c at [c*CNT_W +: CNT_W]
- color_in  in  NUM_CH*3  colour codes, channel c at [c*3 +: 3]
- load  in  1  capture request, one-cycle strobe
- blink_en  in  NUM_CH  per-channel blink enable, level, sampled live
- seg  out  7  segment bus {g..a}, polarity per SEG_ACTIVE_LOW
- dig_sel  out  3*NUM_CH  one-hot digit enable, active-high
- busy  out  1  conversion in progress
- frame_tick  out  1  one-cycle pulse when scan wraps to digit 0

## Operation
- Digit map: index 2c = units of channel c, 2c+1 = tens of channel c, 2*NUM_CH+c = colour of channel c.
- Capture: load high while busy=0 → latch all counts and colours; each count > 99 saturates to 99, then truncated to 7 bits.
- Conversion: 7 double-dabble shift cycles, all channels in parallel, then one commit cycle writing all display digits and colours atomically. Display registers never show partial results.
- load while busy=1 → pending flag set (multiple loads collapse to one); cycle after commit, a new capture of current inputs starts.
- Tens digit 0 → blanked (all segments off); units always shown, so count 0 shows "0".
- Colour digit: 3-bit code zero-extended to 4 bits, decoded as hex glyph.
- Blink: phase register toggles every BLINK_FRAMES frame_ticks; when phase=1 and blink_en[c]=1, all three digits of channel c blank. dig_sel still scans.
- Scan: prescaler 0..SCAN_DIV-1; at terminal count digit index advances, wrapping 3*NUM_CH-1 → 0.

## Timing
- Reset: seg = all-off (7'h7F if SEG_ACTIVE_LOW else 7'h00), dig_sel = 1 (digit 0), busy=0, frame_tick=0, display digits/colours=0, prescaler=0, index=0, blink phase=0, pending=0.
- busy rises cycle after accepted load, high exactly 8 cycles (7 shift + commit); new digits visible on seg from the cycle after commit.
- seg and dig_sel both registered, change on the same edge; never misaligned.
- frame_tick high for the one cycle in which dig_sel returns to digit 0.
- Reset mid-conversion: conversion aborted, display returns to zeros, pending cleared.
- blink_en change takes effect on next registered seg update (≤1 cycle).

## Structure
- Shared package: digit-map index helpers, colour code constants (RED/YELLOW/GREEN), BCD saturation constant 99, segment blank constant.
- One sub-module: existing giaimabaythanh (4-bit → 7-segment), single instance on the muxed digit; polarity inversion applied after it.
- Double-dabble engine, prescaler/scan counter, blink phase in top level.

## Test plan
- Reset asserted mid-scan → seg all-off, dig_sel=1, busy=0 immediately, asynchronous to clk.
- NUM_CH=2, load count={57,3}, color={1,4} → busy 8 cycles; scan shows 7,5,3,blank,1,4.
- count 150 on channel 0 → digits 9,9; count 0 → units "0", tens blank.
- load, then second load 3 cycles later with new values → busy 8 cycles, drops 1 cycle, 8 more; final display = second values; no intermediate mix.
- SCAN_DIV=4, BLINK_FRAMES=2, blink_en=2'b01 → channel 0 digits blank in alternate 2-frame windows; channel 1 always lit.
- SCAN_DIV=4 → dig_sel one-hot, advances every 4 cycles, frame_tick every 24 cycles coincident with dig_sel=1.
